// File: rtl/aes_access_controller.sv
// Gatekeeper in front of the AES core: authorises the requesting agent, issues a
// one-cycle start, waits for completion or timeout, and locks out repeat offenders.
module aes_access_controller #(
    parameter logic [3:0] VALID_TOKEN_MASK = 4'b0010,
    parameter int         MAX_FAILS        = 3,
    parameter int         LOCKOUT_CYCLES   = 64,
    parameter int         TIMEOUT_CYCLES   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   agent_token,
    input  logic         start_encrypt,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         core_start,
    output logic [127:0] core_plaintext,
    output logic [127:0] core_key,
    input  logic         core_done,
    input  logic [127:0] core_ciphertext,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic         done,
    output logic         done_latched,
    output logic         access_denied,
    output logic         timeout_err,
    output logic         locked
);

    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [FW-1:0]  fail_cnt_reg, fail_cnt_next;
    logic [TW-1:0]  timer_reg, timer_next;
    logic [LW-1:0]  lock_cnt_reg, lock_cnt_next;
    logic           core_start_reg, core_start_next;
    logic [127:0]   core_plaintext_reg, core_plaintext_next;
    logic [127:0]   core_key_reg, core_key_next;
    logic [127:0]   ciphertext_reg, ciphertext_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic           done_latched_reg, done_latched_next;
    logic           access_denied_reg, access_denied_next;
    logic           timeout_err_reg, timeout_err_next;
    logic           locked_reg, locked_next;

    logic [3:0]     token_hit;
    logic           token_ok;
    logic [FW-1:0]  fail_inc;

    // One comparator per possible token value, enabled by the mask bit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_token
            assign token_hit[gi] = VALID_TOKEN_MASK[gi] && (agent_token == 2'(gi));
        end
    endgenerate

    assign token_ok = |token_hit;
    assign fail_inc = (fail_cnt_reg == FAIL_MAX) ? fail_cnt_reg : fail_cnt_reg + 1'b1;

    always_comb begin
        state_next          = state_reg;
        fail_cnt_next       = fail_cnt_reg;
        timer_next          = timer_reg;
        lock_cnt_next       = lock_cnt_reg;
        core_start_next     = 1'b0;
        core_plaintext_next = core_plaintext_reg;
        core_key_next       = core_key_reg;
        ciphertext_next     = ciphertext_reg;
        done_next           = 1'b0;
        done_latched_next   = done_latched_reg;
        access_denied_next  = 1'b0;
        timeout_err_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_encrypt) begin
                    if (token_ok) begin
                        core_plaintext_next = plaintext;
                        core_key_next       = key;
                        done_latched_next   = 1'b0;
                        fail_cnt_next       = '0;
                        core_start_next     = 1'b1;
                        state_next          = ISSUE;
                    end else begin
                        access_denied_next = 1'b1;
                        fail_cnt_next      = fail_inc;
                        if (fail_inc == FAIL_MAX) begin
                            lock_cnt_next = '0;
                            state_next    = LOCKOUT;
                        end
                    end
                end
            end
            ISSUE: begin
                timer_next = '0;
                state_next = WAIT;
            end
            WAIT: begin
                // A completion in the final timeout cycle still counts as success.
                if (core_done) begin
                    ciphertext_next   = core_ciphertext;
                    done_next         = 1'b1;
                    done_latched_next = 1'b1;
                    state_next        = IDLE;
                end else if (timer_reg == TIMER_LAST) begin
                    timeout_err_next = 1'b1;
                    state_next       = IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            LOCKOUT: begin
                if (lock_cnt_reg == LOCK_LAST) begin
                    fail_cnt_next = '0;
                    state_next    = IDLE;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next   = (state_next == ISSUE) || (state_next == WAIT);
        locked_next = (state_next == LOCKOUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            fail_cnt_reg       <= '0;
            timer_reg          <= '0;
            lock_cnt_reg       <= '0;
            core_start_reg     <= 1'b0;
            core_plaintext_reg <= '0;
            core_key_reg       <= '0;
            ciphertext_reg     <= '0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
            done_latched_reg   <= 1'b0;
            access_denied_reg  <= 1'b0;
            timeout_err_reg    <= 1'b0;
            locked_reg         <= 1'b0;
        end else begin
            state_reg          <= state_next;
            fail_cnt_reg       <= fail_cnt_next;
            timer_reg          <= timer_next;
            lock_cnt_reg       <= lock_cnt_next;
            core_start_reg     <= core_start_next;
            core_plaintext_reg <= core_plaintext_next;
            core_key_reg       <= core_key_next;
            ciphertext_reg     <= ciphertext_next;
            busy_reg           <= busy_next;
            done_reg           <= done_next;
            done_latched_reg   <= done_latched_next;
            access_denied_reg  <= access_denied_next;
            timeout_err_reg    <= timeout_err_next;
            locked_reg         <= locked_next;
        end
    end

    assign core_start     = core_start_reg;
    assign core_plaintext = core_plaintext_reg;
    assign core_key       = core_key_reg;
    assign ciphertext     = ciphertext_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign done_latched   = done_latched_reg;
    assign access_denied  = access_denied_reg;
    assign timeout_err    = timeout_err_reg;
    assign locked         = locked_reg;

endmodule

// File: tb/tb_aes_access_controller.sv
// Directed bench for aes_access_controller with a latency-20 behavioural AES core
// and a ciphertext scoreboard popped on every done pulse.
module tb_aes_access_controller;

    localparam logic [127:0] KEY_V = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_V  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_V  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int CORE_LAT = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   agent_token;
    logic         start_encrypt;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         core_start;
    logic [127:0] core_plaintext;
    logic [127:0] core_key;
    logic         core_done;
    logic [127:0] core_ciphertext;
    logic [127:0] ciphertext;
    logic         busy, done, done_latched, access_denied, timeout_err, locked;

    aes_access_controller dut (
        .clk(clk), .rst(rst), .agent_token(agent_token), .start_encrypt(start_encrypt),
        .plaintext(plaintext), .key(key), .core_start(core_start),
        .core_plaintext(core_plaintext), .core_key(core_key), .core_done(core_done),
        .core_ciphertext(core_ciphertext), .ciphertext(ciphertext), .busy(busy),
        .done(done), .done_latched(done_latched), .access_denied(access_denied),
        .timeout_err(timeout_err), .locked(locked)
    );

    always #5 clk = ~clk;

    // Reference cipher: the known test vector, otherwise a simple keyed mix.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] k);
        if (pt == PT_V && k == KEY_V) return CT_V;
        return pt ^ {k[63:0], k[127:64]} ^ 128'ha5a5_5a5a_0f0f_f0f0_1234_5678_9abc_def0;
    endfunction

    // Behavioural core: not reset by rst, so an in-flight result can arrive late.
    logic         core_enable;
    int           core_cnt = 0;
    logic [127:0] model_pt = '0, model_key = '0;
    initial core_done = 1'b0;
    initial core_ciphertext = '0;
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start && core_enable) begin
            core_cnt  <= CORE_LAT;
            model_pt  <= core_plaintext;
            model_key <= core_key;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end else if (core_cnt == 1) begin
            core_cnt        <= 0;
            core_done       <= 1'b1;
            core_ciphertext <= core_fn(model_pt, model_key);
        end
    end

    logic [127:0] exp_q[$];
    int total = 0, bad = 0;
    int cyc = 0, n_start = 0, n_done = 0, n_denied = 0, n_timeout = 0, n_locked = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [127:0] e;
        @(negedge clk);
        cyc++;
        if (core_start)    n_start++;
        if (access_denied) n_denied++;
        if (timeout_err)   n_timeout++;
        if (locked)        n_locked++;
        if (done === 1'b1) begin
            n_done++;
            chk("sb_expected_present", 128'(exp_q.size() > 0), 128'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_ciphertext", ciphertext, e);
            end
        end
    endtask

    task automatic request(input logic [1:0] tok, input logic [127:0] pt,
                           input logic [127:0] k, input bit expect_result);
        agent_token   = tok;
        plaintext     = pt;
        key           = k;
        start_encrypt = 1'b1;
        if (expect_result) exp_q.push_back(core_fn(pt, k));
        tick();
        start_encrypt = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0 = n_done;
        int i = 0;
        while (n_done == d0 && i < 100) begin
            tick();
            i++;
        end
        chk(tag, 128'(n_done - d0), 128'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int s0, d0, dn0, l0, c0, i;
        logic [127:0] pt5, key5;
        rst = 1'b1; agent_token = 2'd0; start_encrypt = 1'b0;
        plaintext = '0; key = '0; core_enable = 1'b1;
        idle(3);
        chk("reset_flags", 128'({core_start, busy, done, done_latched, access_denied, timeout_err, locked}), 128'd0);
        chk("reset_ct", ciphertext, 128'd0);
        chk("reset_core_data", core_plaintext | core_key, 128'd0);
        rst = 1'b0;
        idle(2);

        // 1: authorised request, vector result
        s0 = n_start;
        request(2'd1, PT_V, KEY_V, 1'b1);
        chk("t1_core_start_latency", 128'(core_start), 128'd1);
        chk("t1_busy", 128'(busy), 128'd1);
        chk("t1_core_pt", core_plaintext, PT_V);
        chk("t1_core_key", core_key, KEY_V);
        wait_done("t1_done_seen");
        chk("t1_ct", ciphertext, CT_V);
        chk("t1_done_latched", 128'(done_latched), 128'd1);
        chk("t1_busy_after", 128'(busy), 128'd0);
        tick();
        chk("t1_done_one_cycle", 128'(done), 128'd0);
        chk("t1_one_start", 128'(n_start - s0), 128'd1);

        // 2: unauthorised request is denied, state held
        s0 = n_start;
        request(2'd0, 128'h1111, 128'h2222, 1'b0);
        chk("t2_denied_pulse", 128'(access_denied), 128'd1);
        tick();
        chk("t2_denied_one_cycle", 128'(access_denied), 128'd0);
        idle(25);
        chk("t2_no_start", 128'(n_start - s0), 128'd0);
        chk("t2_ct_held", ciphertext, CT_V);
        chk("t2_done_latched_held", 128'(done_latched), 128'd1);

        // a good request clears the fail count and done_latched
        request(2'd1, 128'hdead_beef, 128'hcafe_f00d, 1'b1);
        chk("t3pre_done_latched_cleared", 128'(done_latched), 128'd0);
        wait_done("t3pre_done_seen");

        // 3: three denials lock out for the full lockout window
        dn0 = n_denied;
        s0  = n_start;
        request(2'd0, '0, '0, 1'b0);
        tick();
        request(2'd2, '0, '0, 1'b0);
        tick();
        chk("t3_not_locked_yet", 128'(locked), 128'd0);
        l0 = n_locked;
        request(2'd3, '0, '0, 1'b0);
        chk("t3_locked", 128'(locked), 128'd1);
        idle(10);
        request(2'd1, PT_V, KEY_V, 1'b0);
        i = 0;
        while (locked === 1'b1 && i < 200) begin
            tick();
            i++;
        end
        chk("t3_lock_cycles", 128'(n_locked - l0), 128'd64);
        chk("t3_denials", 128'(n_denied - dn0), 128'd3);
        chk("t3_no_start_locked", 128'(n_start - s0), 128'd0);
        request(2'd1, PT_V, KEY_V, 1'b1);
        chk("t3_accept_after", 128'(core_start), 128'd1);
        wait_done("t3_done_seen");
        chk("t3_ct", ciphertext, CT_V);

        // 4: core never completes -> timeout
        core_enable = 1'b0;
        d0 = n_done;
        c0 = cyc;
        request(2'd1, 128'h4444, 128'h5555, 1'b0);
        c0 = cyc;
        i = 0;
        while (timeout_err !== 1'b1 && i < 200) begin
            tick();
            i++;
        end
        chk("t4_timeout_seen", 128'(timeout_err), 128'd1);
        chk("t4_timeout_latency", 128'(cyc - c0), 128'd65);
        chk("t4_busy", 128'(busy), 128'd0);
        chk("t4_done_latched", 128'(done_latched), 128'd0);
        chk("t4_ct_held", ciphertext, CT_V);
        tick();
        chk("t4_timeout_one_cycle", 128'(timeout_err), 128'd0);
        chk("t4_no_done", 128'(n_done - d0), 128'd0);
        core_enable = 1'b1;

        // 5: token change and re-pulse during WAIT are ignored
        pt5 = 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0;
        key5 = 128'h1357_9bdf_0246_8ace_fdb9_7531_eca8_6420;
        s0 = n_start; dn0 = n_denied; d0 = n_done;
        request(2'd1, pt5, key5, 1'b1);
        idle(3);
        request(2'd0, 128'h9999, 128'h8888, 1'b0);
        wait_done("t5_done_seen");
        chk("t5_ct", ciphertext, core_fn(pt5, key5));
        idle(30);
        chk("t5_one_result", 128'(n_done - d0), 128'd1);
        chk("t5_one_start", 128'(n_start - s0), 128'd1);
        chk("t5_no_denial", 128'(n_denied - dn0), 128'd0);

        // 6: reset during WAIT discards the in-flight result
        request(2'd1, 128'h6666, 128'h7777, 1'b0);
        idle(5);
        rst = 1'b1;
        tick();
        chk("t6_reset_flags", 128'({core_start, busy, done, done_latched, access_denied, timeout_err, locked}), 128'd0);
        chk("t6_reset_ct", ciphertext, 128'd0);
        chk("t6_reset_core_data", core_plaintext | core_key, 128'd0);
        rst = 1'b0;
        d0 = n_done;
        idle(30);
        chk("t6_late_done_ignored", 128'(n_done - d0), 128'd0);
        chk("t6_ct_still_zero", ciphertext, 128'd0);
        request(2'd1, PT_V, KEY_V, 1'b1);
        wait_done("t6_done_seen");
        chk("t6_ct", ciphertext, CT_V);
        chk("sb_drained", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
